// File: rtl/fetch_ctrl_if.sv
// Instruction-fetch bus bundle: instruction-memory port, redirect input,
// decode-side valid/ready output and status counters.
interface fetch_ctrl_if;
    logic [9:0]  im_addr;
    logic [31:0] im_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fetch_cnt;

    // Fetch controller side
    modport master (
        output im_addr,
        input  im_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output fault,
        output fetch_cnt
    );

    // Memory / decode / branch-unit side
    modport slave (
        input  im_addr,
        output im_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  fault,
        input  fetch_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Single-entry instruction fetch stage: sequential PC, decode backpressure,
// redirect flush and sticky fault on misaligned or out-of-range fetch.
module fetch_ctrl #(
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

    // 33-bit span so a window ending exactly at 2^32 is still representable
    localparam logic [32:0] IM_SPAN = 33'(IM_WORDS) << 2;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pc_off;
    logic        pc_legal;
    logic        out_valid, out_valid_n;
    logic [31:0] out_instr, out_instr_n;
    logic [31:0] out_pc, out_pc_n;
    logic        fault, fault_n;
    logic [31:0] fetch_cnt, fetch_cnt_n;
    logic        accept;
    logic        slot_free;

    assign pc_off   = pc - IM_BASE;
    assign pc_legal = (pc[1:0] == 2'b00) && (pc >= IM_BASE) && ({1'b0, pc_off} < IM_SPAN);

    assign accept    = out_valid && bus.out_ready;
    assign slot_free = !out_valid || bus.out_ready;

    assign bus.im_addr   = pc_off[11:2];
    assign bus.out_valid = out_valid;
    assign bus.out_instr = out_instr;
    assign bus.out_pc    = out_pc;
    assign bus.fault     = fault;
    assign bus.fetch_cnt = fetch_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            pc        <= IM_BASE;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            fault     <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            out_valid <= out_valid_n;
            out_instr <= out_instr_n;
            out_pc    <= out_pc_n;
            fault     <= fault_n;
            fetch_cnt <= fetch_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        out_valid_n = out_valid;
        out_instr_n = out_instr;
        out_pc_n    = out_pc;
        fault_n     = fault;
        // Acceptance is counted even in a redirect cycle
        fetch_cnt_n = fetch_cnt + 32'(accept);

        if ((state != BOOT) && bus.redirect_valid) begin
            state_n     = RUN;
            pc_n        = bus.redirect_pc;
            out_valid_n = 1'b0;
            fault_n     = 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state_n = RUN;
                end
                RUN: begin
                    if (slot_free) begin
                        if (pc_legal) begin
                            out_instr_n = bus.im_data;
                            out_pc_n    = pc;
                            out_valid_n = 1'b1;
                            pc_n        = pc + 32'd4;
                        end else begin
                            // Any pending output is being accepted this cycle
                            state_n     = FAULT;
                            fault_n     = 1'b1;
                            out_valid_n = 1'b0;
                        end
                    end
                end
                FAULT: begin
                    out_valid_n = 1'b0;
                    fault_n     = 1'b1;
                end
                default: begin
                    state_n = BOOT;
                end
            endcase
        end
    end
endmodule
